// File: rtl/branch_target_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer_if
// Description : Fetch-side lookup and execute-side training signals of the
//               branch target buffer. Optional statistics outputs are present
//               only when BTB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_target_buffer_if;
  // Fetch-stage lookup
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  // Execute-stage resolution / training
  logic        BrValidE;
  logic [31:0] PCE;
  logic        BranchE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
`ifdef BTB_STATS_EN
  logic [31:0] BrCountE;
  logic [31:0] MispCountE;

  modport master (
    output PCF, BrValidE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, BrCountE, MispCountE
  );
  modport slave (
    input  PCF, BrValidE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, BrCountE, MispCountE
  );
`else
  modport master (
    output PCF, BrValidE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE
  );
  modport slave (
    input  PCF, BrValidE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE
  );
`endif
endinterface : branch_target_buffer_if
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped BTB with 2-bit saturating direction counters.
//               Combinational fetch lookup, execute-stage training and
//               misprediction detection. Optional macro BTB_STATS_EN adds
//               saturating resolved-branch and misprediction counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
  parameter int ENTRIES = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  branch_target_buffer_if.slave btb
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Table storage
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [29:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [29:0]      target_d [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  // Address decomposition; PC[1:0] take no part in indexing or tagging
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             f_hit;
  logic             e_hit;
  logic             pred_taken;
  logic             mispredict;
  logic             unused_pc_lsbs;

  assign f_idx = btb.PCF[IDX_W+1:2];
  assign f_tag = btb.PCF[31:IDX_W+2];
  assign e_idx = btb.PCE[IDX_W+1:2];
  assign e_tag = btb.PCE[31:IDX_W+2];
  assign unused_pc_lsbs = ^{btb.PCF[1:0], btb.PCE[1:0]};

  // Fetch lookup reads the registered table, so a same-cycle update is not visible
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && ctr_q[f_idx][1];
  assign btb.PredTakenF  = pred_taken;
  assign btb.PredTargetF = pred_taken ? {target_q[f_idx], 2'b00} : 32'h0;

  // Redirect on wrong direction, or on taken-taken with a stale target
  assign e_hit      = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign mispredict = btb.BrValidE &&
                      ((btb.BranchE != btb.PredTakenE) ||
                       (btb.BranchE && btb.PredTakenE &&
                        (btb.BrTargetE != btb.PredTargetE)));
  assign btb.MispredictE = mispredict;

  // Training: adjust counter/target on hit, allocate only on a taken miss
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (btb.BrValidE) begin
      if (e_hit) begin
        if (btb.BranchE) begin
          if (ctr_q[e_idx] != CTR_ST) begin
            ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
          end
          target_d[e_idx] = btb.BrTargetE[31:2];
        end else if (ctr_q[e_idx] != CTR_SNT) begin
          ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
        end
      end else if (btb.BranchE) begin
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = btb.BrTargetE[31:2];
        ctr_d[e_idx]    = CTR_WT;
      end
    end
  end

  // Table registers; reset leaves every entry invalid and weakly not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] br_cnt_d;
  logic [31:0] misp_cnt_q;
  logic [31:0] misp_cnt_d;

  // Saturating counts of resolved branches and of mispredictions
  always_comb begin
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (btb.BrValidE && (br_cnt_q != 32'hFFFF_FFFF)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (mispredict && (misp_cnt_q != 32'hFFFF_FFFF)) begin
      misp_cnt_d = misp_cnt_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q   <= 32'd0;
      misp_cnt_q <= 32'd0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign btb.BrCountE   = br_cnt_q;
  assign btb.MispCountE = misp_cnt_q;
`endif

endmodule : branch_target_buffer
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Directed scoreboard bench for branch_target_buffer
//               (ENTRIES=16). Honours BTB_STATS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

  typedef struct {
    string       name;
    bit          chk_f;
    bit          taken;
    logic [31:0] target;
    bit          misp;
    bit          chk_s;
    logic [31:0] br_cnt;
    logic [31:0] misp_cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  branch_target_buffer_if bus ();

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the expectation
  task automatic step(input string nm, input logic [31:0] pcf,
                      input bit bv, input logic [31:0] pce, input bit br,
                      input logic [31:0] brt, input bit pt, input logic [31:0] ptg,
                      input bit e_taken, input logic [31:0] e_tgt, input bit e_misp);
    exp_t e;
    @(posedge clk);
    #1;
    bus.PCF = pcf;  bus.BrValidE = bv; bus.PCE = pce; bus.BranchE = br;
    bus.BrTargetE = brt; bus.PredTakenE = pt; bus.PredTargetE = ptg;
    e = '{name: nm, chk_f: 1'b1, taken: e_taken, target: e_tgt, misp: e_misp,
          chk_s: 1'b0, br_cnt: 32'd0, misp_cnt: 32'd0};
    sb.push_back(e);
  endtask

  // Queue a statistics expectation for the cycle currently being driven
  task automatic stats(input string nm, input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e = '{name: nm, chk_f: 1'b0, taken: 1'b0, target: 32'd0, misp: 1'b0,
          chk_s: 1'b1, br_cnt: bc, misp_cnt: mc};
`ifdef BTB_STATS_EN
    sb.push_back(e);
`endif
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.BrValidE = 1'b0;
  endtask

  // Monitor: compare everything queued for this cycle at the falling edge
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_f) begin
        checks++;
        if (bus.PredTakenF !== e.taken || bus.PredTargetF !== e.target ||
            bus.MispredictE !== e.misp) begin
          errors++;
          $display("FAIL %s: got taken=%0b target=%h misp=%0b, want taken=%0b target=%h misp=%0b",
                   e.name, bus.PredTakenF, bus.PredTargetF, bus.MispredictE,
                   e.taken, e.target, e.misp);
        end
      end
`ifdef BTB_STATS_EN
      if (e.chk_s) begin
        checks++;
        if (bus.BrCountE !== e.br_cnt || bus.MispCountE !== e.misp_cnt) begin
          errors++;
          $display("FAIL %s: got br=%0d misp=%0d, want br=%0d misp=%0d",
                   e.name, bus.BrCountE, bus.MispCountE, e.br_cnt, e.misp_cnt);
        end
      end
`endif
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.PCF = 32'h0; bus.BrValidE = 1'b0; bus.PCE = 32'h0; bus.BranchE = 1'b0;
    bus.BrTargetE = 32'h0; bus.PredTakenE = 1'b0; bus.PredTargetE = 32'h0;

    // In reset: lookups miss, mispredict still follows inputs, no training
    step("rst_idle", 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    stats("rst_stats", 32'd0, 32'd0);
    step("rst_misp", 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0, 0, 32'h0, 1);
    release_reset();

    // Allocation and counter training at 0x40 (index 0, tag 1)
    step("alloc",    32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1);
    stats("stats0", 32'd0, 32'd0);
    step("train1",   32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0);
    step("train2",   32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0);
    step("nt1",      32'h40, 1, 32'h40, 0, 32'h104, 1, 32'h100, 1, 32'h100, 1);
    step("nt2",      32'h40, 1, 32'h40, 0, 32'h104, 1, 32'h100, 1, 32'h100, 1);
    step("weak_nt",  32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    stats("stats5", 32'd5, 32'd3);
    step("nt3",      32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    step("t_from00", 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1);
    // Target change while predicted taken
    step("tgt_chg",  32'h40, 1, 32'h40, 1, 32'h180, 1, 32'h100, 0, 32'h0,   1);
    step("new_tgt",  32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h180, 0);
    stats("stats8", 32'd8, 32'd5);

    // Not-taken miss never allocates nor evicts
    step("nt_miss",  32'h80, 1, 32'h80, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    step("keep_40",  32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h180, 0);
    step("look_80",  32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0);

    // Aliasing: 0x440 shares index 0, evicts 0x40
    step("alias",    32'h40,  1, 32'h440, 1, 32'h200, 0, 32'h0, 1, 32'h180, 1);
    step("evicted",  32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h0,   0);
    step("alias_hit",32'h440, 0, 32'h0,   0, 32'h0,   0, 32'h0, 1, 32'h200, 0);

    // Second index, and PC[1:0] ignored on lookup
    step("idx1",     32'h44, 1, 32'h44, 1, 32'h300, 0, 32'h0,   0, 32'h0,   1);
    step("idx1_lsb", 32'h46, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h300, 0);
    // Mismatched E inputs with BrValidE=0 never mispredict
    step("bv0_quiet",32'h40, 0, 32'h44, 1, 32'h999, 0, 32'h0,   0, 32'h0,   0);
    // Not-taken agreeing with not-taken prediction, targets irrelevant
    step("nt_agree", 32'h44, 1, 32'h1000, 0, 32'h99, 0, 32'h55, 1, 32'h300, 0);

    // Reset asserted during an update: update lost, stats cleared at once
    step("mid_upd",  32'h48, 1, 32'h48, 1, 32'h400, 0, 32'h0,   0, 32'h0,   1);
    stats("stats12", 32'd12, 32'd7);
    #3;
    rst_n = 1'b0;
    step("in_rst",   32'h48, 1, 32'h48, 1, 32'h400, 0, 32'h0,   0, 32'h0,   1);
    stats("stats_rst", 32'd0, 32'd0);
    release_reset();
    step("post_48",  32'h48,  0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    step("post_440", 32'h440, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    step("post_44",  32'h44,  0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_branch_target_buffer
`default_nettype wire

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters for the RV32I pipeline core. Fetch stage looks up PCF and gets a combinational taken/target prediction; execute stage feeds back the resolved outcome from the branch decision unit (BranchE) and the computed target, which trains the table and flags mispredictions to the hazard unit. It is the prediction end of the branch-resolution path: EX decides, this block predicts and learns.

## Interface
- ENTRIES, 16: number of table entries; power of two, 4..256; IDX_W = log2(ENTRIES)
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous reset, active-low
- PCF  input  32  fetch-stage PC to look up
- PredTakenF  output  1  prediction: branch taken at PCF
- PredTargetF  output  32  predicted target; 32'h0 when PredTakenF=0
- BrValidE  input  1  a conditional branch resolves in EX this cycle (BranchTypeE != NOBRANCH, not stalled, not flushed)
- PCE  input  32  PC of the resolving branch
- BranchE  input  1  resolved direction, 1 = taken
- BrTargetE  input  32  resolved target address
- PredTakenE  input  1  PredTakenF carried through pipeline registers for this branch
- PredTargetE  input  32  PredTargetF carried through pipeline registers
- MispredictE  output  1  redirect request to hazard unit

## Operation
- Entry fields: valid (1), tag (32-2-IDX_W bits), target (30 bits, word address; bits [1:0] implied 0), ctr (2 bits).
- Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]. PC[1:0] ignored.
- Lookup (combinational): hit = valid & tag match. PredTakenF = hit & ctr[1]. PredTargetF = {target,2'b00} if PredTakenF else 32'h0.
- Update when BrValidE=1, at rising edge:
  - hit, BranchE=1: ctr = min(ctr+1, 3); target = BrTargetE[31:2].
  - hit, BranchE=0: ctr = max(ctr-1, 0); target unchanged.
  - miss, BranchE=1: allocate (evict any occupant): valid=1, tag, target=BrTargetE[31:2], ctr=2'b10.
  - miss, BranchE=0: no change (not-taken branches never allocate).
- BrValidE=0: no state change regardless of other E inputs.
- MispredictE = BrValidE & ((BranchE != PredTakenE) | (BranchE & PredTakenE & (BrTargetE != PredTargetE))). Combinational.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

## Timing
- Reset (rst_n=0, asynchronous): all valid=0, ctr=2'b01, tag/target=0. Outputs during/after reset: PredTakenF=0, PredTargetF=32'h0, MispredictE follows inputs (0 if BrValidE=0).
- Lookup latency 0 cycles (same cycle as PCF). Update visible to lookup from the cycle after the training edge.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents (no bypass).
- Reset asserted mid-update: reset wins; the update is lost.
- Aliasing: two PCs with the same index and different tags evict each other; no replacement policy beyond overwrite.

## Configuration
- BTB_STATS_EN defined: adds outputs BrCountE (32) and MispCountE (32), reset to 0 by rst_n. BrCountE increments on every cycle with BrValidE=1; MispCountE increments when MispredictE=1. Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset then PCF=32'h0000_0040 -> PredTakenF=0, PredTargetF=0; BrValidE=1, PCE=0x40, BranchE=1, BrTargetE=0x100, PredTakenE=0 -> MispredictE=1; next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x100.
- Train PCE=0x40 taken 3 times (ctr 10->11->11), then not-taken once -> ctr 10, PredTakenF still 1; second not-taken -> ctr 01, PredTakenF=0.
- Not-taken branch at PCE=0x80 on empty table -> no allocation; lookup 0x80 gives PredTakenF=0, MispredictE=0 when PredTakenE=0.
- Alias: ENTRIES=16, allocate 0x40 taken to 0x100, then 0x440 taken to 0x200 -> lookup 0x40 misses (PredTakenF=0), 0x440 hits with 0x200.
- Target change: hit at 0x40 with PredTakenE=1, PredTargetE=0x100, BranchE=1, BrTargetE=0x180 -> MispredictE=1; next lookup returns 0x180.
- BTB_STATS_EN: 5 resolved branches, 2 mispredicted -> BrCountE=5, MispCountE=2; assert rst_n=0 mid-sequence -> both 0 immediately.
